// File: rtl/rv_defs.sv
// Shared RV32I encoding constants and field-tuple enums used by the IMEM loader
// and the decoder/immediate-generator side.
package rv_defs;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {KindR, KindLw, KindSw, KindBeq} kind_e;
    typedef enum logic [1:0] {FnAdd, FnSub, FnAnd, FnOr} funct_e;

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} enc_state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational field-tuple to RV32I word packer with immediate range/alignment check.
// Out-of-range tuples produce the canonical NOP and raise bad_o.
module inst_pack
    import rv_defs::*;
(
    input  logic [1:0]  kind_i,
    input  logic [1:0]  funct_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        bad_o
);

    logic [31:0] word;
    logic        bad;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        fits12;
    logic        fits13;

    // A signed value fits N bits when every bit above N-1 equals the sign bit.
    assign fits12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign fits13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);

    always_comb begin
        word = NOP_WORD;
        bad  = 1'b0;
        f3   = F3_ADD_SUB;
        f7   = F7_BASE;
        unique case (kind_e'(kind_i))
            KindR: begin
                unique case (funct_e'(funct_i))
                    FnAdd: f3 = F3_ADD_SUB;
                    FnSub: begin
                        f3 = F3_ADD_SUB;
                        f7 = F7_SUB;
                    end
                    FnAnd: f3 = F3_AND;
                    FnOr:  f3 = F3_OR;
                endcase
                word = {f7, rs2_i, rs1_i, f3, rd_i, OP_R};
            end
            KindLw: begin
                bad  = !fits12;
                word = {imm_i[11:0], rs1_i, F3_LW, rd_i, OP_LOAD};
            end
            KindSw: begin
                bad  = !fits12;
                word = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OP_STORE};
            end
            KindBeq: begin
                bad  = !fits13 || imm_i[0];
                word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                        imm_i[4:1], imm_i[11], OP_BRANCH};
            end
        endcase
        if (bad) begin
            word = NOP_WORD;
        end
    end

    assign word_o = word;
    assign bad_o  = bad;

endmodule

// File: rtl/inst_encoder.sv
// IMEM loader: accepts decoded field tuples, packs them into RV32I words and writes them
// to consecutive word addresses, one write strobe per accepted tuple.
module inst_encoder
    import rv_defs::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [1:0]        in_funct,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] Base = ADDR_W'(BASE_ADDR);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              fin_q, fin_d;

    logic [31:0] pack_word;
    logic        pack_bad;
    logic        at_max;
    logic        accept;

    inst_pack u_pack (
        .kind_i  (in_kind),
        .funct_i (in_funct),
        .rd_i    (in_rd),
        .rs1_i   (in_rs1),
        .rs2_i   (in_rs2),
        .imm_i   (in_imm),
        .word_o  (pack_word),
        .bad_o   (pack_bad)
    );

    assign at_max   = (addr_q == '1);
    assign in_ready = (state_q == StAccept) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        err_d      = err_q;
        fin_d      = fin_q;
        unique case (state_q)
            StIdle: ;
            StAccept: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = pack_word;
                    fin_d   = in_last || at_max;
                    state_d = StWrite;
                    // Filling the last slot without in_last means the program was truncated.
                    if (pack_bad || (at_max && !in_last)) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_addr_d = addr_q;
                        end
                    end
                end
            end
            StWrite: begin
                state_d = fin_q ? StDone : StAccept;
                if (!at_max) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDone: ;
        endcase
        if (start) begin
            state_d    = StAccept;
            addr_d     = Base;
            err_d      = 1'b0;
            err_addr_d = '0;
            fin_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= Base;
            err_addr_q <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
            fin_q      <= fin_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule
